// File: rtl/mode_switch.sv
// mode_switch: selects one of N_MODES game cores.
// key_next/key_prev rising edges step the active mode with wrap-around.
// Each accepted step sends a RST_CYCLES-long one-hot reset pulse to the
// incoming core, then holds one settle cycle before returning to idle.
// win/lose from the active core are registered and gated off while a
// switch is in progress and for the cycle after it ends.
// Optional build macro MODE_SWITCH_LOCK_EN adds a 'lock' input that
// blocks new switches while in idle.
module mode_switch #(
    parameter int N_MODES    = 2,
    parameter int RST_CYCLES = 4,
    parameter int INIT_MODE  = 0,
    localparam int MW        = (N_MODES > 2) ? $clog2(N_MODES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_next,
    input  logic               key_prev,
`ifdef MODE_SWITCH_LOCK_EN
    input  logic               lock,
`endif
    input  logic [N_MODES-1:0] win_in,
    input  logic [N_MODES-1:0] lose_in,
    output logic [MW-1:0]      mode_sel,
    output logic [N_MODES-1:0] mode_reset,
    output logic               busy,
    output logic               win,
    output logic               lose
);

    localparam logic [MW-1:0]      LAST_MODE = MW'(N_MODES - 1);
    localparam logic [MW-1:0]      RST_MODE  = MW'(INIT_MODE);
    localparam logic [7:0]         LAST_CNT  = 8'(RST_CYCLES - 1);
    localparam logic [N_MODES-1:0] ONE_HOT   = N_MODES'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST,
        ST_SETTLE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [MW-1:0]        mode_sel_q, mode_sel_d;
    logic [N_MODES-1:0]   mode_reset_q, mode_reset_d;
    logic                 busy_q, busy_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;
    logic                 key_next_q, key_next_d;
    logic                 key_prev_q, key_prev_d;
    logic                 armed_q, armed_d;
    logic                 next_edge, prev_edge;
    logic                 lock_int;
    logic                 flag_gate;

`ifdef MODE_SWITCH_LOCK_EN
    assign lock_int = lock;
`else
    assign lock_int = 1'b0;
`endif

    // Edge detection; armed_q masks the first clock after reset so that a
    // key held through reset release is captured as a level, not an edge.
    always_comb begin
        key_next_d = key_next;
        key_prev_d = key_prev;
        armed_d    = 1'b1;
        next_edge  = key_next & ~key_next_q & armed_q;
        prev_edge  = key_prev & ~key_prev_q & armed_q;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mode_sel_q   <= RST_MODE;
            mode_reset_q <= '0;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            key_next_q   <= 1'b0;
            key_prev_q   <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_sel_q   <= mode_sel_d;
            mode_reset_q <= mode_reset_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            key_next_q   <= key_next_d;
            key_prev_q   <= key_prev_d;
            armed_q      <= armed_d;
        end
    end

    // Next-state logic: accept a single-direction edge in idle, time the
    // reset pulse, then spend one settle cycle before going idle again.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_sel_d = mode_sel_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!lock_int && (next_edge ^ prev_edge)) begin
                    state_d = ST_RST;
                    if (next_edge) begin
                        mode_sel_d = (mode_sel_q == LAST_MODE) ? '0
                                                               : mode_sel_q + MW'(1);
                    end else begin
                        mode_sel_d = (mode_sel_q == '0) ? LAST_MODE
                                                        : mode_sel_q - MW'(1);
                    end
                end
            end
            ST_RST: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic; flags are gated on both current and next busy so the
    // cycle in which busy falls still reports zero.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        mode_reset_d = (state_d == ST_RST) ? (ONE_HOT << mode_sel_d) : '0;
        flag_gate    = busy_d | busy_q;
        win_d        = win_in[mode_sel_q] & ~flag_gate;
        lose_d       = lose_in[mode_sel_q] & ~flag_gate;
    end

    assign mode_sel   = mode_sel_q;
    assign mode_reset = mode_reset_q;
    assign busy       = busy_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_mode_switch.sv
// Self-checking bench for mode_switch (N_MODES=3, RST_CYCLES=4, INIT_MODE=0).
// A cycle-indexed reference model predicts every output after each clock.
module tb_mode_switch;

    localparam int N    = 3;
    localparam int R    = 4;
    localparam int INIT = 0;
    localparam int MW   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_next, key_prev;
`ifdef MODE_SWITCH_LOCK_EN
    logic          lock;
`endif
    logic [N-1:0]  win_in, lose_in;
    logic [MW-1:0] mode_sel;
    logic [N-1:0]  mode_reset;
    logic          busy, win, lose;

    int total = 0;
    int bad   = 0;

    mode_switch #(.N_MODES(N), .RST_CYCLES(R), .INIT_MODE(INIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_next   (key_next),
        .key_prev   (key_prev),
`ifdef MODE_SWITCH_LOCK_EN
        .lock       (lock),
`endif
        .win_in     (win_in),
        .lose_in    (lose_in),
        .mode_sel   (mode_sel),
        .mode_reset (mode_reset),
        .busy       (busy),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    // Reference model: m_e counts clock edges, m_t0 is the edge at which the
    // last switch was accepted. Busy spans edges t0..t0+R, pulse t0..t0+R-1.
    int m_mode;
    int m_e = 0;
    int m_t0;
    bit m_primed, m_kn_q, m_kp_q, m_win, m_lose;

    function automatic bit busy_after(int e);
        return (e - m_t0) >= 0 && (e - m_t0) <= R;
    endfunction

    function automatic bit pulse_after(int e);
        return (e - m_t0) >= 0 && (e - m_t0) <= R - 1;
    endfunction

    task automatic model_reset();
        m_mode   = INIT;
        m_primed = 0;
        m_kn_q   = 0;
        m_kp_q   = 0;
        m_t0     = m_e - 1000;
        m_win    = 0;
        m_lose   = 0;
    endtask

    task automatic model_edge();
        int e;
        int old;
        bit bb, ba, ne, pe, lk;
        e   = m_e + 1;
        old = m_mode;
        bb  = busy_after(m_e);
        ne  = key_next && !m_kn_q && m_primed;
        pe  = key_prev && !m_kp_q && m_primed;
`ifdef MODE_SWITCH_LOCK_EN
        lk  = lock;
`else
        lk  = 0;
`endif
        if (!bb && !lk && (ne != pe)) begin
            m_mode = ne ? (m_mode + 1) % N : (m_mode + N - 1) % N;
            m_t0   = e;
        end
        ba     = busy_after(e);
        m_win  = (bb || ba) ? 1'b0 : win_in[old];
        m_lose = (bb || ba) ? 1'b0 : lose_in[old];
        m_kn_q   = key_next;
        m_kp_q   = key_prev;
        m_primed = 1;
        m_e      = e;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [31:0] exp_pulse;
        exp_pulse = pulse_after(m_e) ? (32'd1 << m_mode) : 32'd0;
        chk({ph, "/mode_sel"}, 32'(mode_sel), 32'(m_mode));
        chk({ph, "/mode_reset"}, 32'(mode_reset), exp_pulse);
        chk({ph, "/busy"}, 32'(busy), 32'(busy_after(m_e)));
        chk({ph, "/win"}, 32'(win), 32'(m_win));
        chk({ph, "/lose"}, 32'(lose), 32'(m_lose));
    endtask

    string phase;

    task automatic cycle();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_outputs(phase);
    endtask

    task automatic press(input bit nx, input bit pv);
        key_next = nx;
        key_prev = pv;
        cycle();
        key_next = 0;
        key_prev = 0;
        cycle();
    endtask

    task automatic settle();
        repeat (R + 3) cycle();
    endtask

    task automatic async_reset();
        #2;
        reset = 0;
        model_reset();
        #1;
        check_outputs({phase, "_async"});
        cycle();
        reset = 1;
    endtask

    initial begin
        int rc, bc;
        // 1: reset state, key held through reset release
        phase    = "reset";
        reset    = 0;
        key_next = 1;
        key_prev = 0;
        win_in   = '0;
        lose_in  = '0;
`ifdef MODE_SWITCH_LOCK_EN
        lock     = 0;
`endif
        model_reset();
        cycle();
        cycle();
        reset = 1;
        phase = "held_key";
        repeat (3) cycle();
        chk("held_key_no_switch", 32'(mode_sel), 32'(INIT));
        key_next = 0;
        cycle();

        // 2: walk to mode 2, then next from 2 wraps to 0; measure pulse/busy
        phase = "to_mode2";
        press(1, 0); settle();
        press(1, 0); settle();
        phase = "wrap_next";
        rc = 0;
        bc = 0;
        key_next = 1;
        for (int i = 0; i < R + 4; i++) begin
            cycle();
            key_next = 0;
            if (mode_reset == 3'b001) rc++;
            if (busy) bc++;
        end
        chk("pulse_len", 32'(rc), 32'(R));
        chk("busy_len", 32'(bc), 32'(R + 1));
        chk("wrap_next_mode", 32'(mode_sel), 32'd0);

        // 3: prev from 0 wraps to N-1; simultaneous edges cancel
        phase = "wrap_prev";
        press(0, 1); settle();
        chk("wrap_prev_mode", 32'(mode_sel), 32'(N - 1));
        phase = "both_edges";
        press(1, 1); settle();
        chk("both_edges_mode", 32'(mode_sel), 32'(N - 1));

        // 4: flag muxing and gating across a switch
        phase = "flags";
        press(1, 0); settle();
        press(1, 0); settle();
        win_in  = 3'b010;
        lose_in = 3'b101;
        cycle();
        chk("win_mode1", 32'(win), 32'd1);
        win_in  = 3'b111;
        lose_in = 3'b111;
        phase = "flags_switch";
        press(1, 0); settle();
        win_in  = 3'b011;
        lose_in = 3'b100;
        cycle();
        cycle();
        win_in  = 3'b100;
        cycle();
        cycle();
        win_in  = '0;
        lose_in = '0;

        // 5: edge during RST ignored; reset mid-RST aborts
        phase = "edge_in_rst";
        key_next = 1; cycle();
        key_next = 0; cycle();
        key_next = 1; cycle();
        key_next = 0; settle();
        chk("single_advance", 32'(mode_sel), 32'd0);
        phase = "mid_rst_reset";
        press(1, 0);
        cycle();
        async_reset();
        settle();

`ifdef MODE_SWITCH_LOCK_EN
        // 6: lock blocks switching in idle; an active switch completes
        phase = "lock";
        lock = 1;
        press(1, 0); settle();
        chk("locked_mode", 32'(mode_sel), 32'(INIT));
        lock = 0;
        key_next = 1; cycle();
        key_next = 0; lock = 1; settle();
        lock = 0;
        press(0, 1); settle();
`endif

        // Randomised phase
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            key_next = ($urandom_range(0, 3) == 0);
            key_prev = ($urandom_range(0, 4) == 0);
            win_in   = N'($urandom);
            lose_in  = N'($urandom);
`ifdef MODE_SWITCH_LOCK_EN
            lock     = ($urandom_range(0, 5) == 0);
`endif
            if ($urandom_range(0, 120) == 0) async_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
